program_loader: RTL and testbench

- Host-side byte-stream loader that drives the core's external load interface: address, data, per-RAM write strobes and `run`.
- Parses a byte-oriented command stream from a UART/FIFO front end and performs burst word writes into instruction or data RAM.
- Toggles `run` to start and stop the core.
- Sits between the host link and the core top level; the only master of the core's load interface.

---
 rtl/program_loader.sv | 155 +++++++++++++++
 tb/tb_program_loader.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// Byte-stream loader: parses header/address/count/payload into 32-bit word writes on the core load port.
// Strobe follows the 4th payload byte by one cycle; in_ready drops only during that write cycle.
module program_loader #(
  parameter int         ADDRESS_WIDTH  = 16,
  parameter logic [7:0] CMD_WRITE_INST = 8'h01,
  parameter logic [7:0] CMD_WRITE_DATA = 8'h02,
  parameter logic [7:0] CMD_RUN        = 8'h03,
  parameter logic [7:0] CMD_STOP       = 8'h04
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [7:0]               in_data,
  output logic                     in_ready,
  output logic [ADDRESS_WIDTH-1:0] ext_write_address,
  output logic [31:0]              ext_write_data,
  output logic                     ext_enable_write_inst,
  output logic                     ext_enable_write_data,
  output logic                     run,
  output logic                     busy,
  output logic                     error,
  output logic [15:0]              words_written
);

  typedef enum logic [2:0] {IDLE, ADDR_LO, ADDR_HI, COUNT, DATA, WRITE} state_t;

  state_t                   state, state_n;
  logic [ADDRESS_WIDTH-1:0] address, address_n;
  logic [8:0]               remaining, remaining_n;
  logic [1:0]               byte_index, byte_index_n;
  logic [23:0]              word, word_n;
  logic                     target_inst, target_inst_n;
  logic                     drop, drop_n;
  logic                     run_n, error_n;
  logic [15:0]              words_written_n;
  logic [ADDRESS_WIDTH-1:0] write_address_n;
  logic [31:0]              write_data_n;
  logic                     write_inst_n, write_data_en_n;
  logic                     transfer;

  assign transfer = in_valid & in_ready;

  always_comb begin
    state_n         = state;
    address_n       = address;
    remaining_n     = remaining;
    byte_index_n    = byte_index;
    word_n          = word;
    target_inst_n   = target_inst;
    drop_n          = drop;
    run_n           = run;
    error_n         = error;
    words_written_n = words_written;
    write_address_n = ext_write_address;
    write_data_n    = ext_write_data;
    write_inst_n    = 1'b0;
    write_data_en_n = 1'b0;
    case (state)
      IDLE: if (transfer) begin
        if (in_data == CMD_WRITE_INST || in_data == CMD_WRITE_DATA) begin
          target_inst_n = (in_data == CMD_WRITE_INST);
          drop_n        = run;
          state_n       = ADDR_LO;
        end else if (in_data == CMD_RUN) begin
          run_n = 1'b1;
        end else if (in_data == CMD_STOP) begin
          run_n = 1'b0;
        end else begin
          error_n = 1'b1;
        end
      end
      ADDR_LO: if (transfer) begin
        address_n[7:0] = in_data;
        state_n        = ADDR_HI;
      end
      ADDR_HI: if (transfer) begin
        address_n[15:8] = in_data;
        state_n         = COUNT;
      end
      COUNT: if (transfer) begin
        // A zero count byte encodes a full 256-word burst.
        remaining_n  = (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
        byte_index_n = 2'd0;
        state_n      = DATA;
      end
      DATA: if (transfer) begin
        byte_index_n = byte_index + 2'd1;
        case (byte_index)
          2'd0: word_n[7:0]   = in_data;
          2'd1: word_n[15:8]  = in_data;
          2'd2: word_n[23:16] = in_data;
          default: begin
            // Output registers load here so the strobe is visible during WRITE.
            state_n         = WRITE;
            write_address_n = address;
            write_data_n    = {in_data, word};
            if (drop) begin
              error_n = 1'b1;
            end else begin
              write_inst_n    = target_inst;
              write_data_en_n = !target_inst;
              words_written_n = words_written + 16'd1;
            end
          end
        endcase
      end
      WRITE: begin
        address_n    = address + ADDRESS_WIDTH'(4);
        remaining_n  = remaining - 9'd1;
        byte_index_n = 2'd0;
        state_n      = (remaining == 9'd1) ? IDLE : DATA;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state                 <= IDLE;
      address               <= '0;
      remaining             <= '0;
      byte_index            <= '0;
      word                  <= '0;
      target_inst           <= 1'b0;
      drop                  <= 1'b0;
      in_ready              <= 1'b1;
      busy                  <= 1'b0;
      run                   <= 1'b0;
      error                 <= 1'b0;
      words_written         <= '0;
      ext_write_address     <= '0;
      ext_write_data        <= '0;
      ext_enable_write_inst <= 1'b0;
      ext_enable_write_data <= 1'b0;
    end else begin
      state                 <= state_n;
      address               <= address_n;
      remaining             <= remaining_n;
      byte_index            <= byte_index_n;
      word                  <= word_n;
      target_inst           <= target_inst_n;
      drop                  <= drop_n;
      in_ready              <= (state_n != WRITE);
      busy                  <= (state_n != IDLE);
      run                   <= run_n;
      error                 <= error_n;
      words_written         <= words_written_n;
      ext_write_address     <= write_address_n;
      ext_write_data        <= write_data_n;
      ext_enable_write_inst <= write_inst_n;
      ext_enable_write_data <= write_data_en_n;
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Table-driven and randomized checks of program_loader against a stream-level reference parser.
module tb_program_loader;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic [15:0] ext_write_address;
  logic [31:0] ext_write_data;
  logic        ext_enable_write_inst;
  logic        ext_enable_write_data;
  logic        run;
  logic        busy;
  logic        error;
  logic [15:0] words_written;

  program_loader dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .ext_write_address(ext_write_address), .ext_write_data(ext_write_data),
    .ext_enable_write_inst(ext_enable_write_inst), .ext_enable_write_data(ext_enable_write_data),
    .run(run), .busy(busy), .error(error), .words_written(words_written)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        inst;
    logic [15:0] addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    int          start;
    int          len;
    int          n_wr;
    logic [15:0] last_addr;
    logic [31:0] last_data;
    logic        exp_run;
    logic        exp_err;
  } vec_t;

  int          n_vec = 0;
  int          n_bad = 0;
  wr_t         got_q[$];
  wr_t         exp_q[$];
  logic [7:0]  stream[$];
  logic [7:0]  pool[$];
  vec_t        table_v[$];
  logic        m_run;
  logic        m_err;
  logic [15:0] m_words;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s: timed out waiting on DUT", name);
  endtask

  always @(negedge clock) begin
    if (!reset && (ext_enable_write_inst || ext_enable_write_data)) begin
      check("strobes_exclusive", 64'(ext_enable_write_inst & ext_enable_write_data), 64'd0);
      check("ready_low_in_write", 64'(in_ready), 64'd0);
      got_q.push_back('{ext_enable_write_inst, ext_write_address, ext_write_data});
    end
  end

  // Reference parser: walks the whole byte stream and lists the writes it must produce.
  task automatic model();
    int i = 0;
    int n = stream.size();
    while (i < n) begin
      logic [7:0] h = stream[i];
      i++;
      if (h == 8'h01 || h == 8'h02) begin
        logic [15:0] a;
        int cnt;
        if (i + 3 > n) break;
        a = {stream[i+1], stream[i]};
        cnt = (stream[i+2] == 8'd0) ? 256 : int'(stream[i+2]);
        i += 3;
        for (int k = 0; k < cnt && i + 4 <= n; k++) begin
          logic [31:0] w = {stream[i+3], stream[i+2], stream[i+1], stream[i]};
          i += 4;
          if (m_run) m_err = 1'b1;
          else begin
            exp_q.push_back('{h == 8'h01, a, w});
            m_words = m_words + 16'd1;
          end
          a = a + 16'd4;
        end
      end else if (h == 8'h03) m_run = 1'b1;
      else if (h == 8'h04) m_run = 1'b0;
      else m_err = 1'b1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    bit done = 1'b0;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        in_valid = 1'b0;
        in_data = 8'($urandom);
        @(negedge clock);
      end
    end
    in_valid = 1'b1;
    in_data = b;
    for (int t = 0; t < 20 && !done; t++) begin
      done = in_ready;
      @(negedge clock);
    end
    in_valid = 1'b0;
    in_data = 8'($urandom);
    if (!done) timeout_fail("send_byte");
  endtask

  task automatic play(input bit gaps);
    bit idle = 1'b0;
    int n;
    exp_q.delete();
    got_q.delete();
    model();
    foreach (stream[i]) send_byte(stream[i], gaps);
    for (int t = 0; t < 10 && !idle; t++) begin
      idle = !busy;
      if (!idle) @(negedge clock);
    end
    if (!idle) timeout_fail("wait_idle");
    check("idle_ready", 64'(in_ready), 64'd1);
    check("write_count", 64'(got_q.size()), 64'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check("write_record", {15'd0, got_q[i].inst, got_q[i].addr, got_q[i].data},
            {15'd0, exp_q[i].inst, exp_q[i].addr, exp_q[i].data});
    check("run_level", 64'(run), 64'(m_run));
    check("error_flag", 64'(error), 64'(m_err));
    check("words_written", 64'(words_written), 64'(m_words));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    m_run = 1'b0;
    m_err = 1'b0;
    m_words = 16'd0;
    got_q.delete();
    @(negedge clock);
  endtask

  task automatic add_vec(input int nbytes, input logic [127:0] b, input int n_wr,
                         input logic [15:0] la, input logic [31:0] ld, input logic r, input logic e);
    table_v.push_back('{pool.size(), nbytes, n_wr, la, ld, r, e});
    for (int k = 0; k < nbytes; k++) pool.push_back(b[8*(nbytes-1-k) +: 8]);
  endtask

  task automatic send_list(input logic [127:0] b, input int nbytes);
    for (int k = 0; k < nbytes; k++) send_byte(b[8*(nbytes-1-k) +: 8], 1'b0);
  endtask

  initial begin
    add_vec(8,  64'h01000001_78563412, 1, 16'h0000, 32'h12345678, 1'b0, 1'b0);
    add_vec(16, 128'h02100003_11223344_55667788_99aabbcc, 3, 16'h0018, 32'hccbbaa99, 1'b0, 1'b0);
    add_vec(12, 96'h02fcff02_01020304_05060708, 2, 16'h0000, 32'h08070605, 1'b0, 1'b0);
    add_vec(10, 80'h03_01000001_a1b2c3d4_04, 0, 16'h0000, 32'h0, 1'b0, 1'b1);
    add_vec(1,  8'h7f, 0, 16'h0000, 32'h0, 1'b0, 1'b1);
    add_vec(1,  8'h03, 0, 16'h0000, 32'h0, 1'b1, 1'b0);
    add_vec(8,  64'h01200001_03040304, 1, 16'h0020, 32'h04030403, 1'b0, 1'b0);
    add_vec(10, 80'h0304_02000001_deadbeef, 1, 16'h0000, 32'hefbeadde, 1'b0, 1'b0);

    do_reset();
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_run", 64'(run), 64'd0);
    check("rst_error", 64'(error), 64'd0);
    check("rst_words", 64'(words_written), 64'd0);
    check("rst_addr", 64'(ext_write_address), 64'd0);
    check("rst_data", 64'(ext_write_data), 64'd0);
    check("rst_strobes", 64'({ext_enable_write_inst, ext_enable_write_data}), 64'd0);

    foreach (table_v[v]) begin
      do_reset();
      stream.delete();
      for (int k = 0; k < table_v[v].len; k++) stream.push_back(pool[table_v[v].start + k]);
      play(v[0]);
      check("tbl_nwrites", 64'(got_q.size()), 64'(table_v[v].n_wr));
      check("tbl_words", 64'(words_written), 64'(table_v[v].n_wr));
      if (table_v[v].n_wr > 0 && got_q.size() > 0)
        check("tbl_last_write", {got_q[$].addr, got_q[$].data},
              {table_v[v].last_addr, table_v[v].last_data});
      check("tbl_run", 64'(run), 64'(table_v[v].exp_run));
      check("tbl_error", 64'(error), 64'(table_v[v].exp_err));
    end

    // run rises right after the lone RUN byte; the burst is dropped; STOP clears run.
    do_reset();
    send_byte(8'h03, 1'b0);
    check("run_after_first_byte", 64'(run), 64'd1);
    send_list(64'h01000001_a1b2c3d4, 8);
    @(negedge clock);
    check("dropped_no_strobe", 64'(got_q.size()), 64'd0);
    check("dropped_sets_error", 64'(error), 64'd1);
    send_byte(8'h04, 1'b0);
    check("run_after_stop", 64'(run), 64'd0);

    // busy holds between words and falls right after the final strobe cycle.
    do_reset();
    send_list(128'h02100003_11223344_55667788_99aabbcc, 16);
    check("last_strobe_data", 64'(ext_enable_write_data), 64'd1);
    check("busy_during_last", 64'(busy), 64'd1);
    check("last_addr", 64'(ext_write_address), 64'h18);
    @(negedge clock);
    check("busy_after_last", 64'(busy), 64'd0);
    check("strobe_one_cycle", 64'(ext_enable_write_data), 64'd0);
    check("three_pulses", 64'(got_q.size()), 64'd3);

    // count byte 0x00 means 256 words
    do_reset();
    stream.delete();
    stream.push_back(8'h01); stream.push_back(8'h00); stream.push_back(8'h01); stream.push_back(8'h00);
    repeat (1024) stream.push_back(8'($urandom));
    play(1'b0);
    check("burst256_count", 64'(got_q.size()), 64'd256);
    check("burst256_words", 64'(words_written), 64'd256);
    if (got_q.size() == 256) check("burst256_last_addr", 64'(got_q[255].addr), 64'h04fc);

    // asynchronous reset during payload byte index 2 of the second word
    do_reset();
    send_list(96'h01400002_11223344_5566, 10);
    check("pre_reset_words", 64'(words_written), 64'd1);
    check("pre_reset_addr", 64'(ext_write_address), 64'h40);
    in_valid = 1'b1;
    in_data = 8'h77;
    #2 reset = 1'b1;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_ready", 64'(in_ready), 64'd1);
    check("arst_words", 64'(words_written), 64'd0);
    check("arst_addr", 64'(ext_write_address), 64'd0);
    check("arst_data", 64'(ext_write_data), 64'd0);
    check("arst_strobes", 64'({ext_enable_write_inst, ext_enable_write_data}), 64'd0);
    @(negedge clock);
    in_valid = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    repeat (4) @(negedge clock);
    check("arst_no_strobe", 64'(got_q.size()), 64'd1);
    check("arst_idle", 64'(busy), 64'd0);

    // randomized command streams, model state carried across rounds
    do_reset();
    for (int round = 0; round < 3; round++) begin
      stream.delete();
      for (int c = 0; c < 25; c++) begin
        int r = int'($urandom_range(0, 9));
        if (r <= 3 || r == 9) begin
          int cnt = int'($urandom_range(1, 5));
          logic [15:0] a = r[0] ? 16'hfff8 : 16'($urandom);
          stream.push_back(r[1] ? 8'h02 : 8'h01);
          stream.push_back(a[7:0]);
          stream.push_back(a[15:8]);
          stream.push_back(8'(cnt));
          repeat (cnt * 4) stream.push_back(8'($urandom_range(0, 7) == 0 ? $urandom_range(1, 4) : $urandom));
        end else if (r <= 5) stream.push_back(8'h03);
        else if (r <= 7) stream.push_back(8'h04);
        else stream.push_back(8'($urandom_range(5, 255)));
      end
      play(1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
